// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO of FIFO_DEPTH words, FIFO_WIDTH bits each.
// Read data, write-ack and overflow/underflow pulses are registered.
// Full/empty/almost flags are decoded combinationally from the occupancy count.
// Optional feature: define FIFO_COUNT_EN to expose the occupancy register as output `count`.
module sync_fifo #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [FIFO_WIDTH-1:0]     data_in,
    input  logic                      wr_en,
    input  logic                      rd_en,
    output logic [FIFO_WIDTH-1:0]     data_out,
    output logic                      wr_ack,
    output logic                      overflow,
    output logic                      underflow,
    output logic                      full,
    output logic                      almostfull,
    output logic                      empty,
`ifdef FIFO_COUNT_EN
    output logic                      almostempty,
    output logic [$clog2(FIFO_DEPTH):0] count
`else
    output logic                      almostempty
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] C_DEPTH_M1 = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] C_ONE      = CW'(1);
    localparam logic [CW-1:0] C_ZERO     = '0;

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [FIFO_WIDTH-1:0] r_data_out;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_do;
    logic                  w_rd_do;

    // Flags decode from occupancy; accepted-operation qualifiers gate on them.
    always_comb begin
        w_full  = (r_count == C_DEPTH);
        w_empty = (r_count == C_ZERO);
        w_wr_do = wr_en & ~w_full;
        w_rd_do = rd_en & ~w_empty;
    end

    // Storage array is not reset; only accepted writes update it.
    always_ff @(posedge clk) begin
        if (w_wr_do) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy, registered read data and the per-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ack    <= w_wr_do;
            r_overflow  <= wr_en & w_full;
            r_underflow <= rd_en & w_empty;
            if (w_wr_do) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_do) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
            // A simultaneous accepted read and write leaves occupancy unchanged.
            case ({w_wr_do, w_rd_do})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output mapping of registered state and combinational flags.
    always_comb begin
        data_out    = r_data_out;
        wr_ack      = r_wr_ack;
        overflow    = r_overflow;
        underflow   = r_underflow;
        full        = w_full;
        empty       = w_empty;
        almostfull  = (r_count == C_DEPTH_M1);
        almostempty = (r_count == C_ONE);
    end

`ifdef FIFO_COUNT_EN
    assign count = r_count;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed bench for sync_fifo with a queue-based reference model
// checked every cycle, plus literal expectations for the scenario steps.
module tb_sync_fifo;

    localparam int W = 16;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] data_out;
    logic         wr_ack, overflow, underflow;
    logic         full, almostfull, empty, almostempty;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout = '0;
    logic         m_ack = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;

    sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
        .full(full), .almostfull(almostfull), .empty(empty), .almostempty(almostempty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: FIFO as a queue, evaluated on the same edges as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_dout = '0;
            m_ack  = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            bit wr_ok, rd_ok;
            wr_ok = wr_en && (q.size() < D);
            rd_ok = rd_en && (q.size() > 0);
            m_ack = wr_ok;
            m_ovf = wr_en && !wr_ok;
            m_unf = rd_en && !rd_ok;
            if (rd_ok) m_dout = q.pop_front();
            if (wr_ok) q.push_back(data_in);
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_data_out",    32'(data_out),    32'(m_dout));
            chk("m_wr_ack",      32'(wr_ack),      32'(m_ack));
            chk("m_overflow",    32'(overflow),    32'(m_ovf));
            chk("m_underflow",   32'(underflow),   32'(m_unf));
            chk("m_full",        32'(full),        32'(q.size() == D));
            chk("m_almostfull",  32'(almostfull),  32'(q.size() == D - 1));
            chk("m_empty",       32'(empty),       32'(q.size() == 0));
            chk("m_almostempty", 32'(almostempty), 32'(q.size() == 1));
        end
    end

    task automatic step(input logic w, input logic r, input logic [W-1:0] d);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        chk("rst_pulses", 32'({wr_ack, overflow, underflow}), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Read from empty
        step(1'b0, 1'b1, '0);
        chk("t3_underflow", 32'(underflow), 32'd1);
        chk("t3_dout_hold", 32'(data_out), 32'd0);
        chk("t3_empty", 32'(empty), 32'd1);

        // Fill with 1..8
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, W'(i));
            chk("t1_wr_ack", 32'(wr_ack), 32'd1);
            if (i == 7) chk("t1_almostfull7", 32'({almostfull, full}), 32'b10);
            if (i == 8) chk("t1_full8", 32'({almostfull, full}), 32'b01);
        end

        // Write into full FIFO
        step(1'b1, 1'b0, 16'hDEAD);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_wr_ack", 32'(wr_ack), 32'd0);
        chk("t2_full", 32'(full), 32'd1);

        // Simultaneous read and write while full
        step(1'b1, 1'b1, 16'h0009);
        chk("t4_dout", 32'(data_out), 32'h0001);
        chk("t4_overflow", 32'(overflow), 32'd1);
        chk("t4_full", 32'(full), 32'd0);
        chk("t4_count7", 32'(almostfull), 32'd1);

        // Drain: 2..8, never 0xDEAD or 0x0009
        for (int i = 2; i <= 8; i++) begin
            step(1'b0, 1'b1, '0);
            chk("t2_drain", 32'(data_out), 32'(i));
        end
        chk("t2_drain_empty", 32'(empty), 32'd1);

        // Simultaneous read and write while empty
        step(1'b1, 1'b1, 16'h00AA);
        chk("t5_underflow", 32'(underflow), 32'd1);
        chk("t5_wr_ack", 32'(wr_ack), 32'd1);
        chk("t5_almostempty", 32'({almostempty, empty}), 32'b10);
        step(1'b0, 1'b1, '0);
        chk("t5_readback", 32'(data_out), 32'h00AA);
        chk("t5_empty", 32'(empty), 32'd1);

        // Interleaved stream across pointer wrap
        for (int k = 0; k < 20; k++) begin
            step(1'b1, (k >= 2), W'(16'h0100 + k));
            if (k >= 2) chk("t6_order", 32'(data_out), 32'(16'h0100 + k - 2));
        end

        // Asynchronous reset mid-stream
        wr_en = 1'b1;
        rd_en = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_empty", 32'(empty), 32'd1);
        chk("t6_rst_pulses", 32'({wr_ack, overflow, underflow}), 32'd0);
        chk("t6_rst_dout", 32'(data_out), 32'd0);
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, '0);
        chk("t6_post_empty", 32'(empty), 32'd1);
        step(1'b1, 1'b0, 16'h0055);
        step(1'b0, 1'b1, '0);
        chk("t6_post_data", 32'(data_out), 32'h0055);
        step(1'b0, 1'b0, '0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
